// File: rtl/fir_y_packer_pkg.sv
// Shared types for the FIR y-output packer: FSM states plus control and status bundles.
package fir_package;

  localparam int LENGTH_W = 16;

  typedef enum logic [1:0] {
    FSM_IDLE  = 2'd0,
    FSM_PACK  = 2'd1,
    FSM_FLUSH = 2'd2
  } fir_packer_fsm_state_t;

  typedef struct packed {
    logic                start;
    logic [LENGTH_W-1:0] length;
  } fir_packer_ctrl_t;

  typedef struct packed {
    logic busy;
    logic done;
  } fir_packer_flags_t;

  function automatic int lane_bytes(input int sample_width);
    return sample_width / 8;
  endfunction

endpackage

// File: rtl/fir_y_packer_if.sv
// Sample-in / packed-word-out stream pair between the FIR datapath, the packer and the y sink.
interface fir_y_packer_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int SAMPLE_WIDTH = 16
);

  logic [SAMPLE_WIDTH-1:0] in_data_i;
  logic                    in_valid_i;
  logic                    in_ready_o;
  logic [DATA_WIDTH-1:0]   out_data_o;
  logic [DATA_WIDTH/8-1:0] out_strb_o;
  logic                    out_valid_o;
  logic                    out_ready_i;

  modport slave (
    input  in_data_i, in_valid_i, out_ready_i,
    output in_ready_o, out_data_o, out_strb_o, out_valid_o
  );

  modport master (
    output in_data_i, in_valid_i, out_ready_i,
    input  in_ready_o, out_data_o, out_strb_o, out_valid_o
  );

endinterface

// File: rtl/fir_y_packer.sv
// Packs LANES FIR samples per output word; word valid 1 cycle after its last sample is accepted.
// Input stalls while a word waits on the sink; a handshake and the next lane-0 sample overlap with no bubble.
module fir_y_packer
  import fir_package::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                clk_i,
  input  logic                clear_i,
  input  logic                start_i,
  input  logic [LENGTH_W-1:0] length_i,
  fir_y_packer_if.slave       bus,
  output logic                busy_o,
  output logic                done_o
);

  localparam int LANES      = DATA_WIDTH / SAMPLE_WIDTH;
  localparam int STRB_W     = DATA_WIDTH / 8;
  localparam int LANE_BYTES = lane_bytes(SAMPLE_WIDTH);
  localparam int LANE_W     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  fir_packer_fsm_state_t r_state;
  logic [LENGTH_W-1:0]   r_remain;
  logic [LANE_W-1:0]     r_lane;
  logic [DATA_WIDTH-1:0] r_acc_data;
  logic [STRB_W-1:0]     r_acc_strb;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [STRB_W-1:0]     r_out_strb;
  logic                  r_out_valid;
  logic                  r_done;

  fir_packer_ctrl_t      w_ctrl;
  fir_packer_flags_t     w_flags;
  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_out_fire;
  logic                  w_last_sample;
  logic                  w_word_end;
  logic [DATA_WIDTH-1:0] w_next_data;
  logic [STRB_W-1:0]     w_next_strb;

  assign w_ctrl        = '{start: start_i, length: length_i};
  assign w_out_fire    = r_out_valid && bus.out_ready_i;
  assign w_in_ready    = (r_state == FSM_PACK) && (r_remain != '0) &&
                         (!r_out_valid || bus.out_ready_i);
  assign w_accept      = w_in_ready && bus.in_valid_i;
  assign w_last_sample = (r_remain == LENGTH_W'(1));
  assign w_word_end    = (r_lane == LAST_LANE) || w_last_sample;

  // Lane 0 starts a fresh word, so stale upper lanes never leak into a partial final word.
  always_comb begin
    w_next_data = r_acc_data;
    w_next_strb = r_acc_strb;
    if (r_lane == '0) begin
      w_next_data = '0;
      w_next_strb = '0;
    end
    for (int k = 0; k < LANES; k++) begin
      if (r_lane == LANE_W'(k)) begin
        w_next_data[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = bus.in_data_i;
        w_next_strb[k*LANE_BYTES +: LANE_BYTES]     = '1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      r_state     <= FSM_IDLE;
      r_remain    <= '0;
      r_lane      <= '0;
      r_acc_data  <= '0;
      r_acc_strb  <= '0;
      r_out_data  <= '0;
      r_out_strb  <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end
      // A completing word reloads the output in the same cycle the previous one drains.
      if (w_accept) begin
        r_acc_data <= w_next_data;
        r_acc_strb <= w_next_strb;
        r_remain   <= r_remain - LENGTH_W'(1);
        r_lane     <= (r_lane == LAST_LANE) ? '0 : r_lane + 1'b1;
        if (w_word_end) begin
          r_out_data  <= w_next_data;
          r_out_strb  <= w_next_strb;
          r_out_valid <= 1'b1;
        end
      end
      case (r_state)
        FSM_IDLE: begin
          if (w_ctrl.start) begin
            if (w_ctrl.length != '0) begin
              r_state  <= FSM_PACK;
              r_remain <= w_ctrl.length;
              r_lane   <= '0;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        FSM_PACK: begin
          if (w_accept && w_last_sample) begin
            r_state <= FSM_FLUSH;
          end
        end
        FSM_FLUSH: begin
          if (w_out_fire) begin
            r_state <= FSM_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= FSM_IDLE;
      endcase
    end
  end

  assign w_flags = '{busy: (r_state != FSM_IDLE), done: r_done};

  assign busy_o          = w_flags.busy;
  assign done_o          = w_flags.done;
  assign bus.in_ready_o  = w_in_ready;
  assign bus.out_data_o  = r_out_data;
  assign bus.out_strb_o  = r_out_strb;
  assign bus.out_valid_o = r_out_valid;

endmodule

// File: tb/tb_fir_y_packer.sv
// Directed-vector bench for fir_y_packer with 32-bit words of two 16-bit lanes.
module tb_fir_y_packer;

  logic        clk = 1'b0;
  logic        clear;
  logic        start;
  logic [15:0] length;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  fir_y_packer_if #(.DATA_WIDTH(32), .SAMPLE_WIDTH(16)) y_if ();

  fir_y_packer #(.DATA_WIDTH(32), .SAMPLE_WIDTH(16)) dut (
    .clk_i    (clk),
    .clear_i  (clear),
    .start_i  (start),
    .length_i (length),
    .bus      (y_if),
    .busy_o   (busy),
    .done_o   (done)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [15:0] src_q[$];
  logic [31:0] word_q[$];
  logic [3:0]  strb_q[$];
  bit          src_en = 1'b0;
  int          acc_cnt = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          hs_cyc = 0;
  int          s_cyc = 0;
  bit          valid_seen = 1'b0;
  bit          busy_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input int i);
    return (word_q.size() > i) ? word_q[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] strb_at(input int i);
    return (strb_q.size() > i) ? {28'd0, strb_q[i]} : 32'hDEAD_BEEF;
  endfunction

  // Sample source: presents the head of src_q, advancing after each accepted sample.
  initial begin
    y_if.in_valid_i = 1'b0;
    y_if.in_data_i  = '0;
    forever begin
      @(posedge clk); #1;
      if (src_en && src_q.size() > 0) begin
        y_if.in_valid_i = 1'b1;
        y_if.in_data_i  = src_q[0];
      end else begin
        y_if.in_valid_i = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (y_if.in_valid_i && y_if.in_ready_o) begin
        void'(src_q.pop_front());
        acc_cnt++;
      end
      if (y_if.out_valid_o) valid_seen = 1'b1;
      if (busy) busy_seen = 1'b1;
      if (y_if.out_valid_o && y_if.out_ready_i) begin
        word_q.push_back(y_if.out_data_o);
        strb_q.push_back(y_if.out_strb_o);
        hs_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic new_job(input logic [15:0] len);
    word_q.delete();
    strb_q.delete();
    acc_cnt    = 0;
    valid_seen = 1'b0;
    busy_seen  = 1'b0;
    step();
    start  = 1'b1;
    length = len;
    s_cyc  = cyc;
    step();
    start  = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      step();
      n++;
    end
    repeat (3) step();
  endtask

  task automatic wait_acc(input int cnt);
    int n;
    n = 0;
    while (acc_cnt < cnt && n < 100) begin
      step();
      n++;
    end
  endtask

  initial begin
    int d0;
    int n;
    clear  = 1'b1;
    start  = 1'b0;
    length = '0;
    y_if.out_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    check_eq("rst_out_valid", {31'd0, y_if.out_valid_o}, 32'd0);
    check_eq("rst_out_data", y_if.out_data_o, 32'd0);
    check_eq("rst_out_strb", {28'd0, y_if.out_strb_o}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_in_ready", {31'd0, y_if.in_ready_o}, 32'd0);

    // Length 4 with one surplus sample that must never be taken.
    src_q  = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h00FF};
    src_en = 1'b1;
    d0 = done_cnt;
    new_job(16'd4);
    wait_done(d0);
    check_eq("l4_words", word_q.size(), 2);
    check_eq("l4_w0", word_at(0), 32'h0002_0001);
    check_eq("l4_s0", strb_at(0), 32'hF);
    check_eq("l4_w1", word_at(1), 32'h0004_0003);
    check_eq("l4_s1", strb_at(1), 32'hF);
    check_eq("l4_done_cnt", done_cnt - d0, 1);
    check_eq("l4_done_lat", done_cyc - hs_cyc, 1);
    check_eq("l4_accepted", acc_cnt, 4);
    check_eq("l4_extra_left", src_q.size(), 1);
    check_eq("l4_busy_end", {31'd0, busy}, 32'd0);
    src_q.delete();

    // Length 3: final partial word carries only lane 0.
    src_q = '{16'h000A, 16'h000B, 16'h000C};
    d0 = done_cnt;
    new_job(16'd3);
    wait_done(d0);
    check_eq("l3_words", word_q.size(), 2);
    check_eq("l3_w0", word_at(0), 32'h000B_000A);
    check_eq("l3_s0", strb_at(0), 32'hF);
    check_eq("l3_w1", word_at(1), 32'h0000_000C);
    check_eq("l3_s1", strb_at(1), 32'h3);
    check_eq("l3_done_cnt", done_cnt - d0, 1);
    check_eq("l3_done_lat", done_cyc - hs_cyc, 1);

    // Length 6 with the sink stalled after the first word appears.
    src_q = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006};
    y_if.out_ready_i = 1'b0;
    d0 = done_cnt;
    new_job(16'd6);
    n = 0;
    while (!y_if.out_valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("l6_first_vld", {31'd0, y_if.out_valid_o}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      check_eq("l6_hold_data", y_if.out_data_o, 32'h0002_0001);
      check_eq("l6_hold_strb", {28'd0, y_if.out_strb_o}, 32'hF);
      check_eq("l6_hold_in_rdy", {31'd0, y_if.in_ready_o}, 32'd0);
      @(negedge clk);
    end
    check_eq("l6_acc_stalled", acc_cnt, 2);
    @(posedge clk); #1;
    y_if.out_ready_i = 1'b1;
    wait_done(d0);
    check_eq("l6_words", word_q.size(), 3);
    check_eq("l6_w0", word_at(0), 32'h0002_0001);
    check_eq("l6_w1", word_at(1), 32'h0004_0003);
    check_eq("l6_w2", word_at(2), 32'h0006_0005);
    check_eq("l6_s2", strb_at(2), 32'hF);
    check_eq("l6_accepted", acc_cnt, 6);
    check_eq("l6_done_cnt", done_cnt - d0, 1);

    // Length 0: immediate done, never busy, no word.
    d0 = done_cnt;
    new_job(16'd0);
    repeat (3) step();
    check_eq("l0_done_cnt", done_cnt - d0, 1);
    check_eq("l0_done_lat", done_cyc - s_cyc, 1);
    check_eq("l0_valid_seen", {31'd0, valid_seen}, 32'd0);
    check_eq("l0_busy_seen", {31'd0, busy_seen}, 32'd0);

    // Clear after the first of four samples, then a fresh length-2 job.
    src_q = '{16'h0011};
    d0 = done_cnt;
    new_job(16'd4);
    wait_acc(1);
    check_eq("clr_pre_acc", acc_cnt, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    @(negedge clk);
    check_eq("clr_out_valid", {31'd0, y_if.out_valid_o}, 32'd0);
    check_eq("clr_busy", {31'd0, busy}, 32'd0);
    check_eq("clr_out_data", y_if.out_data_o, 32'd0);
    repeat (5) step();
    check_eq("clr_no_done", done_cnt - d0, 0);
    check_eq("clr_no_word", word_q.size(), 0);
    src_q = '{16'h5555, 16'h6666};
    d0 = done_cnt;
    new_job(16'd2);
    wait_done(d0);
    check_eq("clr_l2_words", word_q.size(), 1);
    check_eq("clr_l2_w0", word_at(0), 32'h6666_5555);
    check_eq("clr_l2_s0", strb_at(0), 32'hF);
    check_eq("clr_l2_done", done_cnt - d0, 1);

    // A start pulse mid-job must be ignored.
    src_q = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
    d0 = done_cnt;
    new_job(16'd4);
    wait_acc(2);
    start  = 1'b1;
    length = 16'd8;
    step();
    start  = 1'b0;
    wait_done(d0);
    repeat (3) step();
    check_eq("mid_words", word_q.size(), 2);
    check_eq("mid_w0", word_at(0), 32'h0202_0101);
    check_eq("mid_w1", word_at(1), 32'h0404_0303);
    check_eq("mid_accepted", acc_cnt, 4);
    check_eq("mid_done_cnt", done_cnt - d0, 1);
    check_eq("mid_busy_end", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
